ptp_tx_ts_tracker: RTL and testbench

Sits in the logic clock domain in front of the MAC TX FIFO (`eth_mac_40g_fifo`). It assigns a PTP tag to each outgoing frame that requests a timestamp and inserts that tag into the TX tuser. When the MAC returns a TX timestamp stream, the block matches each timestamp to its pending frame and delivers the timestamp with the caller's cookie. Pending entries whose timestamp never arrives are retired by a timeout, and stale or unknown tags are dropped.

---
 rtl/ptp_tx_ts_tracker_if.sv | 56 +++++
 rtl/ptp_tx_ts_tracker.sv | 161 ++++++++++++++++
 tb/tb_ptp_tx_ts_tracker.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ptp_tx_ts_tracker_if.sv
// Bus bundle for the PTP TX timestamp tracker: frame stream in/out plus the
// returned-timestamp and matched-timestamp streams.
interface ptp_tx_ts_tracker_if #(
   parameter int DATA_WIDTH    = 128,
   parameter int KEEP_WIDTH    = DATA_WIDTH / 8,
   parameter int PTP_TS_WIDTH  = 96,
   parameter int PTP_TAG_WIDTH = 16,
   parameter int COOKIE_WIDTH  = 16
);
   logic [DATA_WIDTH-1:0]      s_axis_tdata;
   logic [KEEP_WIDTH-1:0]      s_axis_tkeep;
   logic                       s_axis_tvalid;
   logic                       s_axis_tready;
   logic                       s_axis_tlast;
   logic [COOKIE_WIDTH+1:0]    s_axis_tuser;

   logic [DATA_WIDTH-1:0]      m_axis_tdata;
   logic [KEEP_WIDTH-1:0]      m_axis_tkeep;
   logic                       m_axis_tvalid;
   logic                       m_axis_tready;
   logic                       m_axis_tlast;
   logic [PTP_TAG_WIDTH+1:0]   m_axis_tuser;

   logic [PTP_TS_WIDTH-1:0]    s_axis_ts_ts;
   logic [PTP_TAG_WIDTH-1:0]   s_axis_ts_tag;
   logic                       s_axis_ts_valid;
   logic                       s_axis_ts_ready;

   logic [PTP_TS_WIDTH-1:0]    m_axis_ts_ts;
   logic [COOKIE_WIDTH-1:0]    m_axis_ts_cookie;
   logic                       m_axis_ts_valid;
   logic                       m_axis_ts_ready;

   // The tracker itself is the slave side of this bundle.
   modport slave (
      input  s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, s_axis_tuser,
      output s_axis_tready,
      output m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
      input  m_axis_tready,
      input  s_axis_ts_ts, s_axis_ts_tag, s_axis_ts_valid,
      output s_axis_ts_ready,
      output m_axis_ts_ts, m_axis_ts_cookie, m_axis_ts_valid,
      input  m_axis_ts_ready
   );

   modport master (
      output s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, s_axis_tuser,
      input  s_axis_tready,
      input  m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
      output m_axis_tready,
      output s_axis_ts_ts, s_axis_ts_tag, s_axis_ts_valid,
      input  s_axis_ts_ready,
      input  m_axis_ts_ts, m_axis_ts_cookie, m_axis_ts_valid,
      output m_axis_ts_ready
   );
endinterface

// File: rtl/ptp_tx_ts_tracker.sv
// Tags timestamp-requesting TX frames, matches returned MAC timestamps back to
// the caller's cookie, and retires entries whose timestamp never comes back.
module ptp_tx_ts_tracker #(
   parameter int DATA_WIDTH      = 128,
   parameter int KEEP_WIDTH      = DATA_WIDTH / 8,
   parameter int PTP_TS_WIDTH    = 96,
   parameter int PTP_TAG_WIDTH   = 16,
   parameter int TAG_INDEX_WIDTH = 4,
   parameter int COOKIE_WIDTH    = 16,
   parameter int TIMEOUT_CYCLES  = 65536
) (
   input  logic                     clk,
   input  logic                     rst,
   ptp_tx_ts_tracker_if.slave       bus,
   output logic [TAG_INDEX_WIDTH:0] pending_count,
   output logic                     stat_timeout,
   output logic                     stat_drop
);
   localparam int SLOTS = 1 << TAG_INDEX_WIDTH;
   localparam int SEQ_W = PTP_TAG_WIDTH - TAG_INDEX_WIDTH;
   localparam int CNT_W = TAG_INDEX_WIDTH + 1;

   typedef enum logic [0:0] {IDLE, BODY} state_t;

   state_t                         state;
   logic [SLOTS-1:0]               slot_valid;
   logic [SEQ_W-1:0]               slot_seq    [SLOTS];
   logic [COOKIE_WIDTH-1:0]        slot_cookie [SLOTS];
   logic [31:0]                    slot_time   [SLOTS];
   logic [TAG_INDEX_WIDTH-1:0]     alloc_ptr;
   logic [TAG_INDEX_WIDTH-1:0]     scan_ptr;
   logic [31:0]                    now;
   logic [PTP_TAG_WIDTH-1:0]       frame_tag;
   logic                           frame_req;

   logic [DATA_WIDTH-1:0]          beat_data;
   logic [KEEP_WIDTH-1:0]          beat_keep;
   logic                           first_beat;
   logic                           in_req;
   logic [COOKIE_WIDTH-1:0]        in_cookie;
   logic                           stall;
   logic                           beat_acc;
   logic                           do_alloc;
   logic [SEQ_W-1:0]               new_seq;
   logic [PTP_TAG_WIDTH-1:0]       new_tag;
   logic [PTP_TAG_WIDTH-1:0]       out_tag;
   logic                           out_req;

   logic [TAG_INDEX_WIDTH-1:0]     ts_idx;
   logic [SEQ_W-1:0]               ts_seq;
   logic                           ts_acc;
   logic                           ts_match;
   logic [31:0]                    age;
   logic                           expire;

   logic                           vld_p1;
   logic [PTP_TS_WIDTH-1:0]        ts_p1;
   logic [COOKIE_WIDTH-1:0]        cookie_p1;

   // Frame path: purely combinational apart from the held tag
   assign beat_data  = bus.s_axis_tdata;
   assign beat_keep  = bus.s_axis_tkeep;
   assign first_beat = (state == IDLE);
   assign in_req     = bus.s_axis_tuser[1];
   assign in_cookie  = bus.s_axis_tuser[COOKIE_WIDTH+1:2];

   assign stall    = first_beat && bus.s_axis_tvalid && in_req && slot_valid[alloc_ptr];
   assign beat_acc = bus.s_axis_tvalid && bus.s_axis_tready;
   assign do_alloc = beat_acc && first_beat && in_req;
   assign new_seq  = slot_seq[alloc_ptr] + SEQ_W'(1);
   assign new_tag  = {new_seq, alloc_ptr};

   assign out_req = first_beat ? in_req : frame_req;
   assign out_tag = first_beat ? (in_req ? new_tag : '0) : frame_tag;

   assign bus.s_axis_tready = bus.m_axis_tready && !stall;
   assign bus.m_axis_tvalid = bus.s_axis_tvalid && !stall;
   assign bus.m_axis_tdata  = beat_data;
   assign bus.m_axis_tkeep  = beat_keep;
   assign bus.m_axis_tlast  = bus.s_axis_tlast;
   assign bus.m_axis_tuser  = {out_tag, out_req, bus.s_axis_tuser[0]};

   // Returned timestamp decode and table lookup
   assign ts_idx   = bus.s_axis_ts_tag[TAG_INDEX_WIDTH-1:0];
   assign ts_seq   = bus.s_axis_ts_tag[PTP_TAG_WIDTH-1:TAG_INDEX_WIDTH];
   assign ts_acc   = bus.s_axis_ts_valid && bus.s_axis_ts_ready;
   assign ts_match = ts_acc && slot_valid[ts_idx] && (slot_seq[ts_idx] == ts_seq);

   // A match landing on the slot being scanned takes precedence over its expiry.
   assign age    = now - slot_time[scan_ptr];
   assign expire = slot_valid[scan_ptr] && (age >= 32'(TIMEOUT_CYCLES))
                   && !(ts_match && (ts_idx == scan_ptr));

   assign bus.s_axis_ts_ready  = !vld_p1 || bus.m_axis_ts_ready;
   assign bus.m_axis_ts_valid  = vld_p1;
   assign bus.m_axis_ts_ts     = ts_p1;
   assign bus.m_axis_ts_cookie = cookie_p1;

   always_ff @(posedge clk) begin
      if (do_alloc) begin
         slot_cookie[alloc_ptr] <= in_cookie;
         slot_time[alloc_ptr]   <= now;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         slot_valid    <= '0;
         for (int i = 0; i < SLOTS; i++) slot_seq[i] <= '0;
         alloc_ptr     <= '0;
         scan_ptr      <= '0;
         now           <= '0;
         frame_tag     <= '0;
         frame_req     <= 1'b0;
         pending_count <= '0;
         stat_timeout  <= 1'b0;
         stat_drop     <= 1'b0;
         vld_p1        <= 1'b0;
         ts_p1         <= '0;
         cookie_p1     <= '0;
      end else begin
         now      <= now + 32'd1;
         scan_ptr <= scan_ptr + TAG_INDEX_WIDTH'(1);

         if (beat_acc) begin
            case (state)
               IDLE: if (!bus.s_axis_tlast) state <= BODY;
               BODY: if (bus.s_axis_tlast)  state <= IDLE;
               default: state <= IDLE;
            endcase
            if (first_beat) begin
               frame_tag <= in_req ? new_tag : '0;
               frame_req <= in_req;
            end
         end

         // Alloc, match and expiry always address distinct slots.
         if (ts_match) slot_valid[ts_idx]   <= 1'b0;
         if (expire)   slot_valid[scan_ptr] <= 1'b0;
         if (do_alloc) begin
            slot_valid[alloc_ptr] <= 1'b1;
            slot_seq[alloc_ptr]   <= new_seq;
            alloc_ptr             <= alloc_ptr + TAG_INDEX_WIDTH'(1);
         end

         pending_count <= pending_count + CNT_W'(do_alloc) - CNT_W'(ts_match) - CNT_W'(expire);
         stat_timeout  <= expire;
         stat_drop     <= ts_acc && !ts_match;

         // ---- stage p1: matched timestamp output register ----
         if (ts_match) begin
            vld_p1    <= 1'b1;
            ts_p1     <= bus.s_axis_ts_ts;
            cookie_p1 <= slot_cookie[ts_idx];
         end else if (bus.m_axis_ts_ready) begin
            vld_p1 <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_ptp_tx_ts_tracker.sv
// Directed bench for ptp_tx_ts_tracker: round trip, full table, stale tag,
// timeout window, output backpressure and untagged frames.
module tb_ptp_tx_ts_tracker;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [4:0] pending_count;
   logic       stat_timeout;
   logic       stat_drop;
   int         vectors = 0;
   int         miscompares = 0;

   ptp_tx_ts_tracker_if #(.DATA_WIDTH(128), .PTP_TS_WIDTH(96), .PTP_TAG_WIDTH(16), .COOKIE_WIDTH(16)) bus ();

   ptp_tx_ts_tracker #(.TIMEOUT_CYCLES(100)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus),
      .pending_count(pending_count),
      .stat_timeout(stat_timeout),
      .stat_drop(stat_drop)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_beat(input logic req, input logic [15:0] cookie, input logic last);
      bus.s_axis_tvalid = 1'b1;
      bus.s_axis_tuser  = {cookie, req, 1'b0};
      bus.s_axis_tlast  = last;
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   initial begin
      int pulses;
      int first_n;
      bus.s_axis_tdata    = '0;
      bus.s_axis_tkeep    = '0;
      bus.s_axis_tvalid   = 1'b0;
      bus.s_axis_tlast    = 1'b0;
      bus.s_axis_tuser    = '0;
      bus.m_axis_tready   = 1'b1;
      bus.s_axis_ts_ts    = '0;
      bus.s_axis_ts_tag   = '0;
      bus.s_axis_ts_valid = 1'b0;
      bus.m_axis_ts_ready = 1'b1;
      step();
      step();

      // Reset state
      check("rst_ts_valid", 128'(bus.m_axis_ts_valid), 128'(0));
      check("rst_ts_ts", 128'(bus.m_axis_ts_ts), 128'(0));
      check("rst_ts_cookie", 128'(bus.m_axis_ts_cookie), 128'(0));
      check("rst_pending", 128'(pending_count), 128'(0));
      check("rst_stat_timeout", 128'(stat_timeout), 128'(0));
      check("rst_stat_drop", 128'(stat_drop), 128'(0));
      check("rst_ts_ready", 128'(bus.s_axis_ts_ready), 128'(1));
      bus.s_axis_tvalid = 1'b1;
      #1;
      check("rst_tvalid_hi", 128'(bus.m_axis_tvalid), 128'(1));
      bus.s_axis_tvalid = 1'b0;
      #1;
      check("rst_tvalid_lo", 128'(bus.m_axis_tvalid), 128'(0));
      rst = 1'b0;
      step();

      // Single round trip: 3-beat frame, tag held on every beat
      bus.s_axis_tdata = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
      bus.s_axis_tkeep = 16'hFFFF;
      drive_beat(1'b1, 16'h1234, 1'b0);
      check("rt_b1_tag", 128'(bus.m_axis_tuser[17:2]), 128'h10);
      check("rt_b1_req", 128'(bus.m_axis_tuser[1]), 128'(1));
      check("rt_b1_tready", 128'(bus.s_axis_tready), 128'(1));
      check("rt_data", bus.m_axis_tdata, 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677);
      check("rt_keep", 128'(bus.m_axis_tkeep), 128'hFFFF);
      step();
      check("rt_pending1", 128'(pending_count), 128'(1));
      drive_beat(1'b0, 16'h0000, 1'b0);
      check("rt_b2_tag", 128'(bus.m_axis_tuser[17:2]), 128'h10);
      check("rt_b2_req", 128'(bus.m_axis_tuser[1]), 128'(1));
      step();
      drive_beat(1'b0, 16'h0000, 1'b1);
      check("rt_b3_tag", 128'(bus.m_axis_tuser[17:2]), 128'h10);
      step();
      bus.s_axis_tvalid = 1'b0;
      bus.s_axis_tlast  = 1'b0;
      bus.s_axis_ts_valid = 1'b1;
      bus.s_axis_ts_tag   = 16'h0010;
      bus.s_axis_ts_ts    = 96'hA5;
      #1;
      check("rt_ts_ready", 128'(bus.s_axis_ts_ready), 128'(1));
      step();
      bus.s_axis_ts_valid = 1'b0;
      #1;
      check("rt_out_valid", 128'(bus.m_axis_ts_valid), 128'(1));
      check("rt_out_ts", 128'(bus.m_axis_ts_ts), 128'hA5);
      check("rt_out_cookie", 128'(bus.m_axis_ts_cookie), 128'h1234);
      check("rt_pending0", 128'(pending_count), 128'(0));
      step();
      check("rt_out_done", 128'(bus.m_axis_ts_valid), 128'(0));

      // Table full: 16 single-beat tagged frames
      do_reset();
      for (int i = 0; i < 16; i++) begin
         drive_beat(1'b1, 16'(256 + i), 1'b1);
         check($sformatf("full_tag%0d", i), 128'(bus.m_axis_tuser[17:2]), 128'(16 + i));
         step();
      end
      bus.s_axis_tvalid = 1'b0;
      #1;
      check("full_pending16", 128'(pending_count), 128'(16));

      // Untagged frame passes while the table is full
      drive_beat(1'b0, 16'h9999, 1'b1);
      check("nots_tready", 128'(bus.s_axis_tready), 128'(1));
      check("nots_tvalid", 128'(bus.m_axis_tvalid), 128'(1));
      check("nots_req", 128'(bus.m_axis_tuser[1]), 128'(0));
      check("nots_tag", 128'(bus.m_axis_tuser[17:2]), 128'(0));
      step();

      // Frame 17 stalls until slot 0 is returned
      drive_beat(1'b1, 16'h0777, 1'b1);
      check("f17_stall_tready", 128'(bus.s_axis_tready), 128'(0));
      check("f17_stall_tvalid", 128'(bus.m_axis_tvalid), 128'(0));
      step();
      step();
      step();
      check("f17_still_stalled", 128'(bus.s_axis_tready), 128'(0));
      bus.s_axis_ts_valid = 1'b1;
      bus.s_axis_ts_tag   = 16'h0010;
      bus.s_axis_ts_ts    = 96'h55;
      step();
      bus.s_axis_ts_valid = 1'b0;
      #1;
      check("f17_tready", 128'(bus.s_axis_tready), 128'(1));
      check("f17_tvalid", 128'(bus.m_axis_tvalid), 128'(1));
      check("f17_tag", 128'(bus.m_axis_tuser[17:2]), 128'h20);
      check("full_ret_valid", 128'(bus.m_axis_ts_valid), 128'(1));
      check("full_ret_ts", 128'(bus.m_axis_ts_ts), 128'h55);
      check("full_ret_cookie", 128'(bus.m_axis_ts_cookie), 128'h100);
      step();
      bus.s_axis_tvalid = 1'b0;
      #1;
      check("f17_pending16", 128'(pending_count), 128'(16));

      // Everything expires, then a stale tag is dropped
      pulses = 0;
      for (int n = 0; n < 300; n++) begin
         step();
         if (stat_timeout) pulses++;
      end
      check("expire_all_pulses", 128'(pulses), 128'(16));
      check("expire_all_pending", 128'(pending_count), 128'(0));
      bus.s_axis_ts_valid = 1'b1;
      bus.s_axis_ts_tag   = 16'h0010;
      bus.s_axis_ts_ts    = 96'h77;
      #1;
      check("stale_ts_ready", 128'(bus.s_axis_ts_ready), 128'(1));
      step();
      bus.s_axis_ts_valid = 1'b0;
      #1;
      check("stale_drop", 128'(stat_drop), 128'(1));
      check("stale_no_out", 128'(bus.m_axis_ts_valid), 128'(0));
      check("stale_pending", 128'(pending_count), 128'(0));
      step();
      check("stale_drop_once", 128'(stat_drop), 128'(0));

      // Timeout window for a single entry
      do_reset();
      drive_beat(1'b1, 16'h4242, 1'b1);
      step();
      bus.s_axis_tvalid = 1'b0;
      #1;
      check("to_pending1", 128'(pending_count), 128'(1));
      pulses  = 0;
      first_n = 0;
      for (int n = 1; n <= 200; n++) begin
         step();
         if (stat_timeout) begin
            pulses++;
            if (first_n == 0) first_n = n;
         end
      end
      check("to_pulses", 128'(pulses), 128'(1));
      check("to_window", 128'(first_n >= 100 && first_n <= 116), 128'(1));
      check("to_pending0", 128'(pending_count), 128'(0));

      // Output backpressure with two returns
      do_reset();
      drive_beat(1'b1, 16'hAAAA, 1'b1);
      step();
      drive_beat(1'b1, 16'hBBBB, 1'b1);
      step();
      bus.s_axis_tvalid   = 1'b0;
      bus.m_axis_ts_ready = 1'b0;
      bus.s_axis_ts_valid = 1'b1;
      bus.s_axis_ts_tag   = 16'h0010;
      bus.s_axis_ts_ts    = 96'h1;
      #1;
      check("bp_first_ready", 128'(bus.s_axis_ts_ready), 128'(1));
      step();
      bus.s_axis_ts_tag = 16'h0011;
      bus.s_axis_ts_ts  = 96'h2;
      #1;
      check("bp_hold_valid", 128'(bus.m_axis_ts_valid), 128'(1));
      check("bp_hold_ts", 128'(bus.m_axis_ts_ts), 128'h1);
      check("bp_hold_cookie", 128'(bus.m_axis_ts_cookie), 128'hAAAA);
      check("bp_block", 128'(bus.s_axis_ts_ready), 128'(0));
      step();
      step();
      check("bp_hold2_ts", 128'(bus.m_axis_ts_ts), 128'h1);
      check("bp_hold2_cookie", 128'(bus.m_axis_ts_cookie), 128'hAAAA);
      check("bp_block2", 128'(bus.s_axis_ts_ready), 128'(0));
      bus.m_axis_ts_ready = 1'b1;
      #1;
      check("bp_release_ready", 128'(bus.s_axis_ts_ready), 128'(1));
      step();
      bus.s_axis_ts_valid = 1'b0;
      #1;
      check("bp_second_valid", 128'(bus.m_axis_ts_valid), 128'(1));
      check("bp_second_ts", 128'(bus.m_axis_ts_ts), 128'h2);
      check("bp_second_cookie", 128'(bus.m_axis_ts_cookie), 128'hBBBB);
      step();
      check("bp_done", 128'(bus.m_axis_ts_valid), 128'(0));
      check("bp_pending0", 128'(pending_count), 128'(0));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
